// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - Hack CPU core: A/D/PC registers around the Hack ALU, one instruction per clock.
// Optional self-loop detection on the halted output is built only when CPU_HALT_EN is defined.

module hack_alu (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);

   logic [15:0] x_z, x_n, y_z, y_n, f_out;

   always_comb begin
      x_z   = zx ? 16'h0000 : x;
      x_n   = nx ? ~x_z : x_z;
      y_z   = zy ? 16'h0000 : y;
      y_n   = ny ? ~y_z : y_z;
      f_out = f ? (x_n + y_n) : (x_n & y_n);
      out   = no ? ~f_out : f_out;
      zr    = (out == 16'h0000);
      ng    = out[15];
   end

endmodule

module cpu_core (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] inM,
   input  logic [15:0] instruction,
   output logic [15:0] outM,
   output logic        writeM,
   output logic [14:0] addressM,
   output logic [14:0] pc,
   output logic        halted
);

   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic [14:0] pc_reg;

   logic        is_c;
   logic [15:0] alu_y;
   logic [15:0] alu_out;
   logic        alu_zr;
   logic        alu_ng;
   logic        jump;

   // C-instruction bits 14:13 carry no meaning for this core
   logic [1:0]  unused_c_bits;
   assign unused_c_bits = instruction[14:13];

   assign is_c  = instruction[15];
   assign alu_y = instruction[12] ? inM : a_reg;

   hack_alu u_alu (
      .x   (d_reg),
      .y   (alu_y),
      .zx  (instruction[11]),
      .nx  (instruction[10]),
      .zy  (instruction[9]),
      .ny  (instruction[8]),
      .f   (instruction[7]),
      .no  (instruction[6]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   assign jump = is_c & ((instruction[2] & alu_ng) |
                         (instruction[1] & alu_zr) |
                         (instruction[0] & ~alu_zr & ~alu_ng));

   assign outM     = alu_out;
   assign writeM   = is_c & instruction[3] & ~reset;
   assign addressM = a_reg[14:0];
   assign pc       = pc_reg;

   // Jump target is the pre-edge A, so a same-instruction d1 load cannot redirect it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_reg  <= 16'h0000;
         d_reg  <= 16'h0000;
         pc_reg <= 15'h0000;
      end else begin
         if (!is_c)
            a_reg <= instruction;
         else if (instruction[5])
            a_reg <= alu_out;
         if (is_c && instruction[4])
            d_reg <= alu_out;
         pc_reg <= jump ? a_reg[14:0] : pc_reg + 15'd1;
      end
   end

`ifdef CPU_HALT_EN
   logic halted_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         halted_reg <= 1'b0;
      else if (jump && (a_reg[14:0] == pc_reg))
         halted_reg <= 1'b1;
   end

   assign halted = halted_reg;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - randomized Hack CPU bench against an instruction-level reference model.

module tb_cpu_core;

`ifdef CPU_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] inM = 16'h0000;
   logic [15:0] instruction = 16'hE308;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM;
   logic [14:0] pc;
   logic        halted;

   int errors = 0;
   int checks = 0;

   logic [15:0] m_a, m_d;
   logic [14:0] m_pc;
   logic        m_halt;
   logic [14:0] prev_pc;

   logic [5:0] comp_tab [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                 6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                 6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                 6'b000111, 6'b000000, 6'b010101};

   cpu_core dut (
      .clock       (clock),
      .reset       (reset),
      .inM         (inM),
      .instruction (instruction),
      .outM        (outM),
      .writeM      (writeM),
      .addressM    (addressM),
      .pc          (pc),
      .halted      (halted)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hack assembler comp mnemonics evaluated directly
   function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] d, input logic [15:0] y);
      case (c)
         6'b101010: return 16'd0;
         6'b111111: return 16'd1;
         6'b111010: return 16'hFFFF;
         6'b001100: return d;
         6'b110000: return y;
         6'b001101: return ~d;
         6'b110001: return ~y;
         6'b001111: return 16'd0 - d;
         6'b110011: return 16'd0 - y;
         6'b011111: return d + 16'd1;
         6'b110111: return y + 16'd1;
         6'b001110: return d - 16'd1;
         6'b110010: return y - 16'd1;
         6'b000010: return d + y;
         6'b010011: return d - y;
         6'b000111: return y - d;
         6'b000000: return d & y;
         6'b010101: return d | y;
         default:   return 16'hxxxx;
      endcase
   endfunction

   task automatic exec(input logic [15:0] ins);
      logic [15:0] mem, r;
      logic        tk;
      @(negedge clock);
      mem = 16'($urandom);
      instruction = ins;
      inM = mem;
      #1;
      r = comp(ins[11:6], m_d, ins[12] ? mem : m_a);
      tk = ins[15] && ((ins[2] && $signed(r) < 0) || (ins[1] && r == 16'd0) ||
                       (ins[0] && $signed(r) > 0));
      if (ins[15]) begin
         chk("outM", outM, r);
         chk("writeM", {15'd0, writeM}, {15'd0, ins[3]});
      end else begin
         chk("writeM_a", {15'd0, writeM}, 16'd0);
      end
      chk("addressM", {1'b0, addressM}, {1'b0, m_a[14:0]});
      chk("pc", {1'b0, pc}, {1'b0, m_pc});
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      @(posedge clock);
      #1;
      if (HALT_EN && tk && m_a[14:0] == m_pc) m_halt = 1'b1;
      m_pc = tk ? m_a[14:0] : m_pc + 15'd1;
      if (ins[15] && ins[4]) m_d = r;
      if (!ins[15]) m_a = ins;
      else if (ins[5]) m_a = r;
   endtask

   task automatic peek(input logic [15:0] ins);
      instruction = ins;
      inM = 16'($urandom);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      instruction = 16'hE308;
      reset = 1'b1;
      #1;
      chk("rst_pc", {1'b0, pc}, 16'd0);
      chk("rst_writeM", {15'd0, writeM}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0; m_halt = 1'b0;
   endtask

   initial begin
      logic [15:0] ins;

      do_reset();
      peek(16'hEC00); chk("rst_A", outM, 16'd0);
      peek(16'hE300); chk("rst_D", outM, 16'd0);

      exec(16'h0005); exec(16'hEC10); exec(16'hE090);
      chk("add_pc", {1'b0, pc}, 16'd3);
      chk("add_A", {1'b0, addressM}, 16'd5);
      peek(16'hE300); chk("add_D", outM, 16'd10);

      exec(16'h0007);
      peek(16'hE308);
      chk("mw_outM", outM, 16'd10);
      chk("mw_writeM", {15'd0, writeM}, 16'd1);
      chk("mw_addr", {1'b0, addressM}, 16'd7);
      prev_pc = pc;
      exec(16'hE308);
      chk("mw_pc", {1'b0, pc}, {1'b0, prev_pc + 15'd1});
      peek(16'hE300); chk("mw_D", outM, 16'd10);

      exec(16'h0064); exec(16'hEA87);
      chk("jmp_pc", {1'b0, pc}, 16'd100);
      exec(16'hEA90);
      prev_pc = pc;
      exec(16'hE301);
      chk("jgt_pc", {1'b0, pc}, {1'b0, prev_pc + 15'd1});

      exec(16'h7FFF); exec(16'hEA87);
      chk("wrap_top", {1'b0, pc}, 16'h7FFF);
      exec(16'h0001);
      chk("wrap_pc", {1'b0, pc}, 16'd0);

      do_reset();
      repeat (4) exec(16'h0000);
      exec(16'h0004); exec(16'h0005); exec(16'hEA87);
      chk("halt_no", {15'd0, halted}, 16'd0);
      chk("halt_pc5", {1'b0, pc}, 16'd5);
      exec(16'hEA87);
      chk("halt_set", {15'd0, halted}, {15'd0, HALT_EN});
      exec(16'h0003);
      chk("halt_run", {1'b0, pc}, 16'd6);
      chk("halt_stick", {15'd0, halted}, {15'd0, HALT_EN});
      do_reset();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(1, 0) == 0) begin
            ins = {1'b0, 15'($urandom)};
         end else begin
            ins = {1'b1, 2'($urandom), 1'($urandom), comp_tab[$urandom_range(17, 0)], 6'($urandom)};
         end
         exec(ins);
      end

      do_reset();
      peek(16'hE300); chk("end_D", outM, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
